// File: rtl/fp_mul_booth_seq.sv
// Iterative IEEE-754-style multiplier: radix-4 Booth significand engine retiring
// DIGITS_PER_CYCLE digits per clock, round-to-nearest-even, flush-to-zero specials.
module fp_mul_booth_seq #(
  parameter int EXP_W            = 8,
  parameter int MAN_W            = 23,
  parameter int DIGITS_PER_CYCLE = 1   // 1, 2 or 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] a_i,
  input  logic [EXP_W+MAN_W:0] b_i,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] result,
  output logic                 overflow,
  output logic                 underflow,
  output logic                 invalid
);

  localparam int SIG_W  = MAN_W + 1;
  localparam int ND     = (SIG_W + 2) / 2;
  localparam int NCYC   = (ND + DIGITS_PER_CYCLE - 1) / DIGITS_PER_CYCLE;
  localparam int ACC_W  = 2 * SIG_W + 4;
  localparam int BEXT_W = 2 * NCYC * DIGITS_PER_CYCLE + 1;
  localparam int CNT_W  = $clog2(NCYC + 1);
  localparam int EW2    = EXP_W + 2;

  localparam logic [CNT_W-1:0]      LAST_CNT  = CNT_W'(NCYC);
  localparam logic signed [EW2-1:0] BIAS_S    = EW2'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW2-1:0] EXP_MAX_S = EW2'((1 << EXP_W) - 1);
  localparam logic signed [EW2-1:0] ONE_S     = EW2'(1);

  typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

  state_t state_reg, state_next;

  logic                     sign_reg;
  logic signed [EW2-1:0]    exp_sum_reg;
  logic [SIG_W-1:0]         a_sig_reg;
  logic [SIG_W-1:0]         b_sig_reg;
  logic                     nan_case_reg;
  logic                     inf_case_reg;
  logic                     zero_case_reg;
  logic [CNT_W-1:0]         cnt_reg;
  logic signed [ACC_W-1:0]  psum_reg;
  logic signed [ACC_W-1:0]  psum_next;
  logic signed [ACC_W-1:0]  acc_reg;
  logic [EXP_W+MAN_W:0]     result_reg;
  logic                     ovf_reg;
  logic                     unf_reg;
  logic                     inv_reg;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = MUL;
      end
      MUL: begin
        if (cnt_reg == LAST_CNT) state_next = NORM;
      end
      NORM: state_next = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- operand decode
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

  assign ea     = a_i[MAN_W +: EXP_W];
  assign eb     = b_i[MAN_W +: EXP_W];
  assign fa     = a_i[MAN_W-1:0];
  assign fb     = b_i[MAN_W-1:0];
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (&ea) && (fa == '0);
  assign b_inf  = (&eb) && (fb == '0);
  assign a_nan  = (&ea) && (|fa);
  assign b_nan  = (&eb) && (|fb);

  // ---------------------------------------------------------------- Booth digits
  // Multiplier padded so every digit slot of every cycle reads a valid triplet;
  // slots past ND see only zero-extension bits and contribute nothing.
  logic [BEXT_W-1:0]       bext;
  logic signed [ACC_W-1:0] a_ext;
  logic signed [ACC_W-1:0] pp [DIGITS_PER_CYCLE];

  assign bext  = {{(BEXT_W-SIG_W-1){1'b0}}, b_sig_reg, 1'b0};
  assign a_ext = $signed({{(ACC_W-SIG_W){1'b0}}, a_sig_reg});

  for (genvar gi = 0; gi < DIGITS_PER_CYCLE; gi++) begin : g_digit
    int unsigned             idx;
    logic [2:0]              trip;
    logic signed [ACC_W-1:0] mag;
    logic signed [ACC_W-1:0] shifted;

    always_comb begin
      idx = 0;
      if (cnt_reg < LAST_CNT)
        idx = 32'(cnt_reg) * 32'(DIGITS_PER_CYCLE) + 32'(gi);
      trip = bext[2*idx +: 3];
      case (trip)
        3'b001, 3'b010: mag = a_ext;
        3'b011:         mag = a_ext <<< 1;
        3'b100:         mag = -(a_ext <<< 1);
        3'b101, 3'b110: mag = -a_ext;
        default:        mag = '0;
      endcase
      shifted = mag <<< (2 * idx);
    end

    assign pp[gi] = shifted;
  end

  always_comb begin
    psum_next = '0;
    for (int k = 0; k < DIGITS_PER_CYCLE; k++)
      psum_next = psum_next + pp[k];
  end

  // ---------------------------------------------------------------- normalise / round
  logic [2*SIG_W-1:0]    prod;
  logic [SIG_W-1:0]      mant;
  logic                  guard, sticky, round_up;
  logic [SIG_W:0]        mant_rnd;
  logic [MAN_W-1:0]      frac_fin;
  logic signed [EW2-1:0] exp_norm, exp_fin;
  logic [EXP_W+MAN_W:0]  res_next;
  logic                  ovf_next, unf_next, inv_next;
  logic                  unused_acc;

  assign prod       = acc_reg[2*SIG_W-1:0];
  assign unused_acc = ^acc_reg[ACC_W-1:2*SIG_W];

  always_comb begin
    if (prod[2*SIG_W-1]) begin
      mant     = prod[2*SIG_W-1 -: SIG_W];
      guard    = prod[SIG_W-1];
      sticky   = |prod[SIG_W-2:0];
      exp_norm = exp_sum_reg + ONE_S;
    end else begin
      mant     = prod[2*SIG_W-2 -: SIG_W];
      guard    = prod[SIG_W-2];
      sticky   = |prod[SIG_W-3:0];
      exp_norm = exp_sum_reg;
    end
    round_up = guard & (sticky | mant[0]);
    mant_rnd = {1'b0, mant} + {{SIG_W{1'b0}}, round_up};
    if (mant_rnd[SIG_W]) begin
      frac_fin = mant_rnd[SIG_W-1:1];
      exp_fin  = exp_norm + ONE_S;
    end else begin
      frac_fin = mant_rnd[MAN_W-1:0];
      exp_fin  = exp_norm;
    end

    res_next = {sign_reg, exp_fin[EXP_W-1:0], frac_fin};
    ovf_next = 1'b0;
    unf_next = 1'b0;
    inv_next = 1'b0;
    if (nan_case_reg) begin
      res_next = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      inv_next = 1'b1;
    end else if (inf_case_reg) begin
      res_next = {sign_reg, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (zero_case_reg) begin
      res_next = {sign_reg, {(EXP_W+MAN_W){1'b0}}};
    end else if (exp_fin >= EXP_MAX_S) begin
      res_next = {sign_reg, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      ovf_next = 1'b1;
    end else if (exp_fin[EW2-1] || exp_fin == '0) begin
      res_next = {sign_reg, {(EXP_W+MAN_W){1'b0}}};
      unf_next = 1'b1;
    end
  end

  // ---------------------------------------------------------------- datapath registers
  // Partial sums are registered before the wide add, so MUL spends one extra
  // drain cycle (cnt_reg == LAST_CNT) folding in the last group.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sign_reg      <= 1'b0;
      exp_sum_reg   <= '0;
      a_sig_reg     <= '0;
      b_sig_reg     <= '0;
      nan_case_reg  <= 1'b0;
      inf_case_reg  <= 1'b0;
      zero_case_reg <= 1'b0;
      cnt_reg       <= '0;
      psum_reg      <= '0;
      acc_reg       <= '0;
      result_reg    <= '0;
      ovf_reg       <= 1'b0;
      unf_reg       <= 1'b0;
      inv_reg       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            sign_reg      <= a_i[EXP_W+MAN_W] ^ b_i[EXP_W+MAN_W];
            exp_sum_reg   <= $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS_S;
            a_sig_reg     <= {~a_zero, fa};
            b_sig_reg     <= {~b_zero, fb};
            nan_case_reg  <= a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
            inf_case_reg  <= a_inf | b_inf;
            zero_case_reg <= a_zero | b_zero;
            cnt_reg       <= '0;
            psum_reg      <= '0;
            acc_reg       <= '0;
          end
        end
        MUL: begin
          acc_reg  <= acc_reg + psum_reg;
          psum_reg <= (cnt_reg != LAST_CNT) ? psum_next : '0;
          cnt_reg  <= cnt_reg + CNT_W'(1);
        end
        NORM: begin
          result_reg <= res_next;
          ovf_reg    <= ovf_next;
          unf_reg    <= unf_next;
          inv_reg    <= inv_next;
        end
        default: ;
      endcase
    end
  end

  assign result    = result_reg;
  assign overflow  = ovf_reg;
  assign underflow = unf_reg;
  assign invalid   = inv_reg;

endmodule
